// File: rtl/am2940.sv
// ---------------------------------------------------------------------------
// am2940 -- DMA address generator (Am2940-style)
//
// Purpose:
//   Holds a 3-bit control register (CR), an address register/counter pair
//   (AR/AC) and a word-count register/counter pair (WR/WC). A 3-bit
//   instruction, sampled on every rising clk edge, loads, reinitializes or
//   steps the counters. Read instructions place CR, WC or AC on dataout
//   combinationally.
//
// Ports:
//   clk      in   1  rising-edge clock for all registers
//   rst_n    in   1  asynchronous active-low reset
//   instr    in   3  instruction code
//   datain   in   8  data bus input for loads
//   cina     in   1  active-low address counter count enable
//   cinw     in   1  active-low word counter count enable
//   address  out  8  current address counter value
//   dataout  out  8  read data (00 when no read instruction)
//   oedata   out  1  high when dataout carries read data
//   cona     out  1  active-low address counter carry-out
//   conw     out  1  active-low word counter carry-out
//   done     out  1  transfer-complete flag
//
// Configuration:
//   AM2940_ADDR_COMPARE_EN -- when defined, done is raised in word-hold mode
//   (CR[1:0] = 10) when AC equals WR; when undefined, done stays low in that
//   mode.
// ---------------------------------------------------------------------------
module am2940 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] instr,
    input  logic [7:0] datain,
    input  logic       cina,
    input  logic       cinw,
    output logic [7:0] address,
    output logic [7:0] dataout,
    output logic       oedata,
    output logic       cona,
    output logic       conw,
    output logic       done
);

    typedef enum logic [2:0] {
        WR_CR   = 3'b000,
        RD_CR   = 3'b001,
        RD_WC   = 3'b010,
        RD_AC   = 3'b011,
        REINIT  = 3'b100,
        LD_ADDR = 3'b101,
        LD_WORD = 3'b110,
        EN_CNT  = 3'b111
    } instr_t;

    // Word counter modes held in CR[1:0]
    localparam logic [1:0] WC_DEC     = 2'b00;
    localparam logic [1:0] WC_CLR_INC = 2'b01;
    localparam logic [1:0] WC_HOLD    = 2'b10;
    localparam logic [1:0] WC_INC     = 2'b11;

    logic [2:0] cr;
    logic [7:0] ar;
    logic [7:0] ac;
    logic [7:0] wr;
    logic [7:0] wc;
    instr_t     op;
    logic [1:0] wc_mode;
    logic       ac_down;

    assign op      = instr_t'(instr);
    assign wc_mode = cr[1:0];
    assign ac_down = cr[2];
    assign address = ac;

    // Register file and counters. In clear-and-increment mode the word
    // counter always restarts from zero on a load or reinitialize, so WR
    // then acts as the compare target for done rather than a start value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr <= 3'b000;
            ar <= 8'h00;
            ac <= 8'h00;
            wr <= 8'h00;
            wc <= 8'h00;
        end else begin
            case (op)
                WR_CR: begin
                    cr <= datain[2:0];
                end
                REINIT: begin
                    ac <= ar;
                    wc <= (wc_mode == WC_CLR_INC) ? 8'h00 : wr;
                end
                LD_ADDR: begin
                    ar <= datain;
                    ac <= datain;
                end
                LD_WORD: begin
                    wr <= datain;
                    wc <= (wc_mode == WC_CLR_INC) ? 8'h00 : datain;
                end
                EN_CNT: begin
                    if (!cina) begin
                        ac <= ac_down ? (ac - 8'd1) : (ac + 8'd1);
                    end
                    if (!cinw) begin
                        case (wc_mode)
                            WC_DEC:     wc <= wc - 8'd1;
                            WC_CLR_INC: wc <= wc + 8'd1;
                            WC_INC:     wc <= wc + 8'd1;
                            default:    wc <= wc;
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read port: combinational from the instruction currently presented
    always_comb begin
        dataout = 8'h00;
        oedata  = 1'b0;
        case (op)
            RD_CR: begin
                dataout = {5'b11111, cr};
                oedata  = 1'b1;
            end
            RD_WC: begin
                dataout = wc;
                oedata  = 1'b1;
            end
            RD_AC: begin
                dataout = ac;
                oedata  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Carry-outs flag that the next enabled step will wrap the counter
    always_comb begin
        cona = 1'b1;
        if (!cina && (ac == (ac_down ? 8'h00 : 8'hFF))) begin
            cona = 1'b0;
        end
    end

    always_comb begin
        conw = 1'b1;
        if (!cinw) begin
            case (wc_mode)
                WC_DEC:     conw = (wc != 8'h00);
                WC_CLR_INC: conw = (wc != 8'hFF);
                WC_INC:     conw = (wc != 8'hFF);
                default:    conw = 1'b1;
            endcase
        end
    end

    // Transfer-complete detection, one rule per word counter mode
    always_comb begin
        done = 1'b0;
        case (wc_mode)
            WC_DEC:     done = (wc == 8'h01);
            WC_CLR_INC: done = (wc == wr);
            WC_INC:     done = (wc == 8'h00);
            default: begin
`ifdef AM2940_ADDR_COMPARE_EN
                done = (ac == wr);
`else
                done = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_am2940.sv
// ---------------------------------------------------------------------------
// tb_am2940 -- self-checking bench for am2940
//
// Directed scenarios for counting, clear-and-increment mode, word-count
// carry, hold mode, control register readback and asynchronous reset,
// followed by randomized instructions checked against a register-level
// reference model. Define AM2940_ADDR_COMPARE_EN for both bench and RTL to
// exercise the address-compare done option.
// ---------------------------------------------------------------------------
module tb_am2940;

    logic       clk;
    logic       rst_n;
    logic [2:0] instr;
    logic [7:0] datain;
    logic       cina;
    logic       cinw;
    logic [7:0] address;
    logic [7:0] dataout;
    logic       oedata;
    logic       cona;
    logic       conw;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cr, m_ar, m_ac, m_wr, m_wc;

    am2940 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .instr   (instr),
        .datain  (datain),
        .cina    (cina),
        .cinw    (cinw),
        .address (address),
        .dataout (dataout),
        .oedata  (oedata),
        .cona    (cona),
        .conw    (conw),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what each output should be, given the model state and the
    // inputs presently applied
    function automatic int exp_dataout();
        case (int'(instr))
            1: return 248 + m_cr;
            2: return m_wc;
            3: return m_ac;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_oedata();
        return (instr == 3'd1) || (instr == 3'd2) || (instr == 3'd3);
    endfunction

    function automatic bit exp_cona();
        int term;
        term = (m_cr >= 4) ? 0 : 255;
        return !((cina == 1'b0) && (m_ac == term));
    endfunction

    function automatic bit exp_conw();
        int mode;
        mode = m_cr % 4;
        if (cinw == 1'b1 || mode == 2) return 1'b1;
        if (mode == 0) return m_wc != 0;
        return m_wc != 255;
    endfunction

    function automatic bit exp_done();
        case (m_cr % 4)
            0: return m_wc == 1;
            1: return m_wc == m_wr;
            3: return m_wc == 0;
            default: begin
`ifdef AM2940_ADDR_COMPARE_EN
                return m_ac == m_wr;
`else
                return 1'b0;
`endif
            end
        endcase
    endfunction

    function automatic void model_reset();
        m_cr = 0; m_ar = 0; m_ac = 0; m_wr = 0; m_wc = 0;
    endfunction

    // Applies the effect of one clock edge with the current inputs
    function automatic void model_clock();
        int mode;
        mode = m_cr % 4;
        case (int'(instr))
            0: m_cr = int'(datain) % 8;
            4: begin
                m_ac = m_ar;
                m_wc = (mode == 1) ? 0 : m_wr;
            end
            5: begin
                m_ar = int'(datain);
                m_ac = int'(datain);
            end
            6: begin
                m_wr = int'(datain);
                m_wc = (mode == 1) ? 0 : int'(datain);
            end
            7: begin
                if (cina == 1'b0) m_ac = (m_ac + ((m_cr >= 4) ? 255 : 1)) % 256;
                if (cinw == 1'b0) begin
                    if (mode == 0) m_wc = (m_wc + 255) % 256;
                    else if (mode != 2) m_wc = (m_wc + 1) % 256;
                end
            end
            default: begin
            end
        endcase
    endfunction

    // Drive inputs in the low clock phase and let outputs settle
    task automatic apply(input logic [2:0] i, input logic [7:0] d,
                         input logic ca, input logic cw);
        @(negedge clk);
        instr  = i;
        datain = d;
        cina   = ca;
        cinw   = cw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr = 3'd7; datain = 8'h00; cina = 1'b1; cinw = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (address !== 8'h00) begin errors++; $display("[TB] FAIL reset_address got %h want 00", address); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dataout got %h want 00", dataout); end
        checks++; if (oedata !== 1'b0) begin errors++; $display("[TB] FAIL reset_oedata got %b want 0", oedata); end
        checks++; if (cona !== 1'b1) begin errors++; $display("[TB] FAIL reset_cona got %b want 1", cona); end
        checks++; if (conw !== 1'b1) begin errors++; $display("[TB] FAIL reset_conw got %b want 1", conw); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_dec();
        logic [7:0] exp_ac [3];
        logic       exp_co [3];
        logic       exp_dn [3];
        exp_ac = '{8'hFE, 8'hFF, 8'h00};
        exp_co = '{1'b1, 1'b0, 1'b1};
        exp_dn = '{1'b0, 1'b1, 1'b0};
        apply(3'd0, 8'h00, 1'b1, 1'b1); tick();
        apply(3'd5, 8'hFD, 1'b1, 1'b1); tick();
        apply(3'd6, 8'h03, 1'b1, 1'b1); tick();
        apply(3'd7, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (address !== exp_ac[k]) begin errors++; $display("[TB] FAIL dec_address[%0d] got %h want %h", k, address, exp_ac[k]); end
            checks++; if (cona !== exp_co[k]) begin errors++; $display("[TB] FAIL dec_cona[%0d] got %b want %b", k, cona, exp_co[k]); end
            checks++; if (done !== exp_dn[k]) begin errors++; $display("[TB] FAIL dec_done[%0d] got %b want %b", k, done, exp_dn[k]); end
        end
        checks++; if (conw !== 1'b0) begin errors++; $display("[TB] FAIL dec_conw_at_00 got %b want 0", conw); end
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL dec_wc_end got %h want 00", dataout); end
        apply(3'd4, 8'h00, 1'b1, 1'b1); tick();
        apply(3'd3, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'hFD) begin errors++; $display("[TB] FAIL reinit_ac got %h want FD", dataout); end
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h03) begin errors++; $display("[TB] FAIL reinit_wc got %h want 03", dataout); end
    endtask

    task automatic test_clear_increment();
        apply(3'd0, 8'h01, 1'b1, 1'b1); tick();
        apply(3'd6, 8'h61, 1'b1, 1'b1); tick();
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL clrinc_load got %h want 00", dataout); end
        apply(3'd7, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h03) begin errors++; $display("[TB] FAIL clrinc_count got %h want 03", dataout); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL clrinc_done got %b want 0", done); end
        apply(3'd4, 8'h00, 1'b1, 1'b1); tick();
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL clrinc_reinit got %h want 00", dataout); end
    endtask

    task automatic test_word_carry();
        apply(3'd0, 8'h03, 1'b1, 1'b1); tick();
        apply(3'd6, 8'hFD, 1'b1, 1'b1); tick();
        apply(3'd7, 8'h00, 1'b1, 1'b0);
        tick();
        checks++; if (conw !== 1'b1) begin errors++; $display("[TB] FAIL inc_conw_fe got %b want 1", conw); end
        tick();
        checks++; if (conw !== 1'b0) begin errors++; $display("[TB] FAIL inc_conw_ff got %b want 0", conw); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL inc_done_00 got %b want 1", done); end
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL inc_wc_wrap got %h want 00", dataout); end
    endtask

    task automatic test_hold_mode();
        apply(3'd0, 8'h06, 1'b1, 1'b1); tick();
        apply(3'd5, 8'h8A, 1'b1, 1'b1); tick();
        apply(3'd6, 8'h61, 1'b1, 1'b1); tick();
        apply(3'd7, 8'h00, 1'b0, 1'b0);
        checks++; if (conw !== 1'b1) begin errors++; $display("[TB] FAIL hold_conw got %b want 1", conw); end
        repeat (3) tick();
        checks++; if (address !== 8'h87) begin errors++; $display("[TB] FAIL hold_address got %h want 87", address); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL hold_done got %b want 0", done); end
        apply(3'd2, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'h61) begin errors++; $display("[TB] FAIL hold_wc got %h want 61", dataout); end
    endtask

    task automatic test_read_cr();
        apply(3'd0, 8'h05, 1'b1, 1'b1); tick();
        apply(3'd1, 8'h00, 1'b1, 1'b1);
        checks++; if (dataout !== 8'hFD) begin errors++; $display("[TB] FAIL rdcr_data got %h want FD", dataout); end
        checks++; if (oedata !== 1'b1) begin errors++; $display("[TB] FAIL rdcr_oe got %b want 1", oedata); end
        apply(3'd5, 8'h10, 1'b1, 1'b1);
        checks++; if (oedata !== 1'b0) begin errors++; $display("[TB] FAIL ldaddr_oe got %b want 0", oedata); end
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL ldaddr_data got %h want 00", dataout); end
        tick();
    endtask

    task automatic test_async_reset();
        apply(3'd0, 8'h03, 1'b1, 1'b1); tick();
        apply(3'd5, 8'h40, 1'b1, 1'b1); tick();
        apply(3'd6, 8'h20, 1'b1, 1'b1); tick();
        apply(3'd7, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (address !== 8'h00) begin errors++; $display("[TB] FAIL async_address got %h want 00", address); end
        instr = 3'd2; #1;
        checks++; if (dataout !== 8'h00) begin errors++; $display("[TB] FAIL async_wc got %h want 00", dataout); end
        instr = 3'd1; #1;
        checks++; if (dataout !== 8'hF8) begin errors++; $display("[TB] FAIL async_cr got %h want F8", dataout); end
        instr = 3'd7; cina = 1'b1; cinw = 1'b1; #1;
        checks++; if (cona !== 1'b1 || conw !== 1'b1) begin errors++; $display("[TB] FAIL async_carry got %b%b want 11", cona, conw); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0] i;
        for (int n = 0; n < 400; n++) begin
            i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) i = 3'd7;
            apply(i, 8'($urandom), 1'($urandom), 1'($urandom));
            checks++; if (int'(address) != m_ac) begin errors++; $display("[TB] FAIL rnd_address[%0d] got %h want %h", n, address, m_ac); end
            checks++; if (int'(dataout) != exp_dataout()) begin errors++; $display("[TB] FAIL rnd_dataout[%0d] got %h want %h", n, dataout, exp_dataout()); end
            checks++; if (oedata !== exp_oedata()) begin errors++; $display("[TB] FAIL rnd_oedata[%0d] got %b want %b", n, oedata, exp_oedata()); end
            checks++; if (cona !== exp_cona()) begin errors++; $display("[TB] FAIL rnd_cona[%0d] got %b want %b", n, cona, exp_cona()); end
            checks++; if (conw !== exp_conw()) begin errors++; $display("[TB] FAIL rnd_conw[%0d] got %b want %b", n, conw, exp_conw()); end
            checks++; if (done !== exp_done()) begin errors++; $display("[TB] FAIL rnd_done[%0d] got %b want %b", n, done, exp_done()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_count_dec();
        test_clear_increment();
        test_word_carry();
        test_hold_mode();
        test_read_cr();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
